// File: rtl/uart_reg_loader_pkg.sv
// Shared definitions for the UART register loader: FSM state encoding,
// bytes per register word and default parameter values.
package loader_pkg;

  localparam int BYTES_PER_WORD     = 4;
  localparam int DEF_ADDR_BUS_WIDTH = 5;
  localparam int DEF_DATA_BUS_WIDTH = 32;
  localparam int DEF_NUM_REGS       = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/uart_reg_loader_word_assembler.sv
// Packs UART bytes MSB-first into a register word; word/word_valid present the
// completed word combinationally in the cycle of its last byte strobe.
module uart_word_assembler
  import loader_pkg::*;
#(
  parameter int NUM_BYTES = BYTES_PER_WORD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [NUM_BYTES*8-1:0]   word,
  output logic                     word_valid
);

  localparam int DATA_W = NUM_BYTES * 8;
  localparam int IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(NUM_BYTES - 1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] word_s;

  assign word_s     = {shift_q[DATA_W-9:0], rx_data};
  assign word       = word_s;
  assign word_valid = rx_valid && !clear && (idx_q == LAST_BYTE);

  // next shift contents and byte position
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (rx_valid) begin
      shift_d = word_s;
      idx_d   = (idx_q == LAST_BYTE) ? '0 : idx_q + IDX_W'(1);
    end else begin
      shift_d = shift_q;
      idx_d   = idx_q;
    end
  end

  // shift register and byte index flops
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/uart_reg_loader.sv
// Loads a frame of register words from a UART byte stream into a register file.
// Define UART_REG_LOADER_CHECKSUM_EN to add a trailing modulo-256 checksum byte.
module uart_reg_loader
  import loader_pkg::*;
#(
  parameter int ADDR_BUS_WIDTH = DEF_ADDR_BUS_WIDTH,
  parameter int DATA_BUS_WIDTH = DEF_DATA_BUS_WIDTH,
  parameter int NUM_REGS       = DEF_NUM_REGS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic [ADDR_BUS_WIDTH-1:0] wr_addr,
  output logic [DATA_BUS_WIDTH-1:0] wr_data,
  output logic                      wr_en,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  localparam logic [ADDR_BUS_WIDTH-1:0] LAST_IDX = ADDR_BUS_WIDTH'(NUM_REGS - 1);

  state_e                    state_q, state_d;
  logic [ADDR_BUS_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_BUS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_BUS_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                      wr_en_q, wr_en_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic                      asm_clear_s;
  logic                      asm_valid_s;
  logic [DATA_BUS_WIDTH-1:0] word_s;
  logic                      word_valid_s;
  logic                      last_word_s;

  assign last_word_s = (idx_q == LAST_IDX);

  uart_word_assembler #(
    .NUM_BYTES (DATA_BUS_WIDTH / 8)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear_s),
    .rx_data    (rx_data),
    .rx_valid   (asm_valid_s),
    .word       (word_s),
    .word_valid (word_valid_s)
  );

  // frame sequencing: next state, word index and write-port values
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    asm_clear_s = 1'b0;
    asm_valid_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = COLLECT;
          idx_d       = '0;
          asm_clear_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        asm_valid_s = rx_valid;
        if (word_valid_s) begin
          state_d = WRITE;
          // word 0 targets the hardwired-zero register and is dropped
          if (idx_q != '0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q;
            wr_data_d = word_s;
          end else begin
            wr_en_d = 1'b0;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      WRITE: begin
        if (!last_word_s) begin
          // a byte landing here already belongs to the next word
          asm_valid_s = rx_valid;
          idx_d       = idx_q + ADDR_BUS_WIDTH'(1);
          state_d     = COLLECT;
        end else begin
`ifdef UART_REG_LOADER_CHECKSUM_EN
          state_d = rx_valid ? DONE : CHECK;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef UART_REG_LOADER_CHECKSUM_EN
      CHECK: begin
        if (rx_valid) begin
          state_d = DONE;
        end else begin
          state_d = CHECK;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef UART_REG_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       error_q, error_d;
  logic       check_fire_s;

  // the checksum byte may arrive during the last WRITE cycle or later in CHECK
  assign check_fire_s = rx_valid &&
                        ((state_q == CHECK) || ((state_q == WRITE) && last_word_s));

  // running byte sum and sticky mismatch flag
  always_comb begin
    sum_d   = asm_clear_s ? 8'h00 : (asm_valid_s ? sum_q + rx_data : sum_q);
    error_d = asm_clear_s ? 1'b0 :
              (check_fire_s ? (error_q | (rx_data != sum_q)) : error_q);
  end

  // checksum accumulator and error flops
  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_q   <= 8'h00;
      error_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_en   = wr_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_uart_reg_loader.sv
// Directed self-checking bench for uart_reg_loader (default parameters).
module tb_uart_reg_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        busy;
  logic        done;
  logic        error;

  int n_checks;
  int n_errors;
  int pulse_cnt;
  int done_cnt;
  int first_addr;
  logic [31:0] mem [0:31];

  localparam logic [31:0] SENTINEL = 32'hBAD0_BAD0;

  uart_reg_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write-port monitor sampled on the falling edge
  always @(negedge clk) begin
    if (wr_en) begin
      pulse_cnt = pulse_cnt + 1;
      if (pulse_cnt == 1) first_addr = int'(wr_addr);
      mem[wr_addr] = wr_data;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic byte_strobe(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      repeat (gap) @(negedge clk);
      byte_strobe(w[31-8*k -: 8]);
    end
  endtask

  function automatic logic [31:0] pattern(input int kind, input int i);
    logic [7:0] b;
    b = 8'(i);
    if (kind == 0) return {24'h000000, b};
    if (kind == 1) return (i == 5) ? 32'hDEAD_BEEF : {b, b ^ 8'h5A, 8'hC3, ~b};
    return 32'h0101_0101;
  endfunction

  // trail < 0 sends the bench-computed checksum as the trailing byte
  task automatic send_frame(input int kind, input int gap, input int trail, input logic exp_err);
    logic [31:0] w;
    logic [7:0]  sum;
    logic [7:0]  trail_b;
    sum = 8'h00;
    pulse_cnt = 0;
    done_cnt = 0;
    for (int a = 0; a < 32; a++) mem[a] = SENTINEL;
    pulse_start();
    check("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      if (kind == 0 && i == 3) pulse_start();
      w = pattern(kind, i);
      send_word(w, gap);
      sum = sum + w[31:24] + w[23:16] + w[15:8] + w[7:0];
      if (i == 0) begin
        check("w0_no_wr_en", {31'd0, wr_en}, 32'd0);
      end else begin
        check("wr_en", {31'd0, wr_en}, 32'd1);
        check("wr_addr", {27'd0, wr_addr}, 32'(i));
        check("wr_data", wr_data, w);
      end
    end
    trail_b = (trail < 0) ? sum : 8'(trail);
`ifdef UART_REG_LOADER_CHECKSUM_EN
    repeat (gap) @(negedge clk);
    byte_strobe(trail_b);
`else
    @(negedge clk);
`endif
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd1);
    check("no_wr_en_in_done", {31'd0, wr_en}, 32'd0);
    check("hold_addr", {27'd0, wr_addr}, 32'd31);
    @(negedge clk);
    check("done_single", {31'd0, done}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("error_end", {31'd0, error}, {31'd0, exp_err});
    // a stray byte after the frame must be ignored in IDLE
    byte_strobe(trail_b);
    repeat (2) @(negedge clk);
    check("pulse_count", 32'(pulse_cnt), 32'd31);
    check("done_count", 32'(done_cnt), 32'd1);
    check("first_addr", 32'(first_addr), 32'd1);
    check("reg0_untouched", mem[0], SENTINEL);
    check("busy_after_stray", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    pulse_cnt = 0;
    done_cnt  = 0;
    first_addr = 0;
    rst      = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // bytes while IDLE do nothing
    for (int i = 0; i < 6; i++) byte_strobe(8'(8'h11 * i));
    repeat (2) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_pulses", 32'(pulse_cnt), 32'd0);
    check("idle_done", 32'(done_cnt), 32'd0);

    // gapped frame with ignored mid-frame start, then back-to-back frame
    send_frame(0, 2, -1, 1'b0);
    send_frame(1, 0, -1, 1'b0);

    // reset in the middle of word 10
    pulse_cnt = 0;
    pulse_start();
    for (int i = 0; i < 10; i++) send_word(pattern(0, i), 1);
    byte_strobe(8'h00);
    byte_strobe(8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("mid_rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    check("mid_rst_wr_data", wr_data, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    byte_strobe(8'h00);
    byte_strobe(8'h0A);
    repeat (3) @(negedge clk);
    check("mid_rst_pulses", 32'(pulse_cnt), 32'd9);
    check("mid_rst_idle", {31'd0, busy}, 32'd0);
    send_frame(0, 1, -1, 1'b0);

`ifdef UART_REG_LOADER_CHECKSUM_EN
    // all-0x01 data sums to 0x80
    send_frame(2, 1, 8'h80, 1'b0);
    send_frame(2, 1, 8'h7F, 1'b1);
    check("error_sticky", {31'd0, error}, 32'd1);
    pulse_start();
    check("error_cleared_by_start", {31'd0, error}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
